// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges branch, mul/div and load-use
// hazards into PC / IF/ID / ID/EX / EX/MEM controls and keeps saturating perf counters.
module pipeline_stall_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             muldiv_start_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_hold_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 2);

  state_t     state, state_next;
  logic [3:0] md_cnt, md_cnt_next;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  assign load_use = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                    ((id_ex_rt_i == if_id_rs_i) ||
                     (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // MD_WAIT holds md_cnt = remaining wait cycles; it exits on its last one so the
  // whole stall (start cycle included) lasts MULDIV_LAT-1 cycles.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_hold_o      = 1'b0;
    ex_mem_flush_o = 1'b0;
    state_next     = RUN;
    md_cnt_next    = 4'd0;
    if (rst_i) begin
      state_next  = RUN;
      md_cnt_next = 4'd0;
    end else if (branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (state == MD_WAIT) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      ex_hold_o      = 1'b1;
      ex_mem_flush_o = 1'b1;
      md_cnt_next    = (md_cnt == 4'd0) ? 4'd0 : md_cnt - 4'd1;
      state_next     = (md_cnt <= 4'd1) ? RUN : MD_WAIT;
    end else if (muldiv_start_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      ex_hold_o      = 1'b1;
      ex_mem_flush_o = 1'b1;
      md_cnt_next    = MD_LOAD;
      state_next     = (MD_LOAD == 4'd0) ? RUN : MD_WAIT;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign stall_inc = !rst_i && !pc_write_o;
  assign flush_inc = !rst_i && branch_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_inc && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed hazard scenarios followed
// by random traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memread = 1'b0;
  logic [4:0]    ex_rt = '0;
  logic [4:0]    id_rs = '0;
  logic [4:0]    id_rt = '0;
  logic          uses_rt = 1'b0;
  logic          branch = 1'b0;
  logic          md_start = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, ex_mem_flush;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passed = 0;

  // model state: remaining mul/div stall cycles after this one, and the two counters
  int m_md_left = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_valid = 1'b0;

  pipeline_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt),
    .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
    .branch_taken_i(branch), .muldiv_start_i(md_start),
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush), .ex_hold_o(ex_hold), .ex_mem_flush_o(ex_mem_flush),
    .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic checkOutput(input string tag, input bit e_pc, input bit e_ifw, input bit e_iff,
                             input bit e_idf, input bit e_hold, input bit e_emf);
    check1({tag, ".pc_write"},     16'(pc_write),     16'(e_pc));
    check1({tag, ".if_id_write"},  16'(if_id_write),  16'(e_ifw));
    check1({tag, ".if_id_flush"},  16'(if_id_flush),  16'(e_iff));
    check1({tag, ".id_ex_flush"},  16'(id_ex_flush),  16'(e_idf));
    check1({tag, ".ex_hold"},      16'(ex_hold),      16'(e_hold));
    check1({tag, ".ex_mem_flush"}, 16'(ex_mem_flush), 16'(e_emf));
    if (m_valid) begin
      check1({tag, ".state"},     16'(state),     (m_md_left > 0) ? 16'd1 : 16'd0);
      check1({tag, ".stall_cnt"}, 16'(stall_cnt), 16'(m_stall));
      check1({tag, ".flush_cnt"}, 16'(flush_cnt), 16'(m_flush));
    end
  endtask

  // drive one cycle of inputs, compare against the model, then advance the model
  task automatic applyStimulus(input string tag, input bit r, input bit mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                               input bit br, input bit ms);
    bit lu, e_pc, e_ifw, e_iff, e_idf, e_hold, e_emf;
    @(negedge clk);
    rst = r; memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    uses_rt = ur; branch = br; md_start = ms;
    #1;
    lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    {e_pc, e_ifw, e_iff, e_idf, e_hold, e_emf} = 6'b110000;
    if (r) begin
    end else if (br) begin
      {e_iff, e_idf, e_emf} = 3'b111;
    end else if (m_md_left > 0 || ms) begin
      {e_pc, e_ifw, e_hold, e_emf} = 4'b0011;
    end else if (lu) begin
      {e_pc, e_ifw, e_idf} = 3'b001;
    end
    checkOutput(tag, e_pc, e_ifw, e_iff, e_idf, e_hold, e_emf);
    if (r) begin
      m_md_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (br && m_flush < CMAX) m_flush++;
      if (br) m_md_left = 0;
      else if (m_md_left > 0) m_md_left--;
      else if (ms) m_md_left = LAT - 2;
    end
    m_valid = 1'b1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 1, 1, 5, 5, 0, 0, 0, 1);
    idle("idle", 1);

    applyStimulus("lu_rs", 0, 1, 5, 5, 0, 0, 0, 0);
    idle("lu_after", 1);
    check1("lu_stall_count", 16'(stall_cnt), 16'd1);
    applyStimulus("lu_rt0", 0, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus("lu_no_uses_rt", 0, 1, 7, 3, 7, 0, 0, 0);
    applyStimulus("lu_uses_rt", 0, 1, 7, 3, 7, 1, 0, 0);

    applyStimulus("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("md_t", 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("md_t1", 0, 1, 5, 5, 0, 0, 0, 1);
    applyStimulus("md_t2", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("md_t3", 0, 0, 0, 0, 0, 0, 0, 0);
    check1("md_stall_count", 16'(stall_cnt), 16'd3);

    applyStimulus("br_md_t", 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("br_md_t1", 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("br_md_t2", 0, 0, 0, 0, 0, 0, 0, 0);
    check1("br_flush_count", 16'(flush_cnt), 16'd1);

    applyStimulus("br_lu", 0, 1, 9, 9, 0, 0, 1, 0);
    idle("br_lu_after", 1);

    applyStimulus("md_rst_t", 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("md_rst_t1", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("md_rst_after", 2);

    for (int i = 0; i < 20; i++) applyStimulus("sat", 0, 1, 4, 4, 0, 0, 0, 0);
    idle("sat_after", 1);
    check1("sat_value", 16'(stall_cnt), 16'd15);

    applyStimulus("rnd_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 59) == 0), $urandom_range(0, 1),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 1),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end
    idle("final", 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
